// File: rtl/display_source_arbiter_pkg.sv
// Shared definitions for the seven-segment display source arbiter.
// Holds the display value width and the arbiter state encoding.
package display_source_arbiter_pkg;

    localparam int NUM_W = 13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        PINNED = 2'd2
    } state_t;

endpackage

// File: rtl/display_source_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start,
// wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Walk offsets from farthest to nearest so the nearest hit is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(start) + i) % N]) begin
                found = 1'b1;
                idx   = W'((int'(start) + i) % N);
            end
        end
    end

endmodule

// File: rtl/display_source_arbiter.sv
// Round-robin owner of the four-digit display driver with a minimum dwell
// per grant and a switch-driven pin override.
module display_source_arbiter
    import display_source_arbiter_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int NUM_W        = display_source_arbiter_pkg::NUM_W,
    parameter int DWELL_CYCLES = 100000000,
    parameter int CNT_W        = 27,
    localparam int SEL_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       req,
    input  logic [N_SRC*NUM_W-1:0] data,
    input  logic                   pin_en,
    input  logic [SEL_W-1:0]       pin_sel,
    output logic [N_SRC-1:0]       grant,
    output logic [SEL_W-1:0]       src_id,
    output logic [NUM_W-1:0]       num_out,
    output logic                   valid_out
);

    state_t           state;
    logic [CNT_W-1:0] dwell_cnt;
    logic [SEL_W-1:0] last_ptr;

    logic [SEL_W-1:0] start_idx;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic [N_SRC-1:0] pick_grant;
    logic [N_SRC-1:0] pin_grant;
    logic             pin_ok;
    logic [NUM_W-1:0] owner_data;
    logic [NUM_W-1:0] pin_data;
    logic             dwell_done;
    logic             owner_req;

    function automatic logic [SEL_W-1:0] next_of(input logic [SEL_W-1:0] p);
        return SEL_W'((int'(p) + 1) % N_SRC);
    endfunction

    assign start_idx  = (state == SHOW) ? next_of(src_id) : next_of(last_ptr);
    assign dwell_done = (dwell_cnt == CNT_W'(DWELL_CYCLES - 1));
    assign owner_req  = |(req & grant);
    assign pin_ok     = |pin_grant;

    rr_pick #(
        .N (N_SRC),
        .W (SEL_W)
    ) u_rr_pick (
        .req   (req),
        .start (start_idx),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Index decode by compare so out-of-range pin_sel values select nothing.
    always_comb begin
        owner_data = '0;
        pin_data   = '0;
        pin_grant  = '0;
        pick_grant = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_id == SEL_W'(i)) owner_data = data[i*NUM_W +: NUM_W];
            if (pin_sel == SEL_W'(i)) begin
                pin_data     = data[i*NUM_W +: NUM_W];
                pin_grant[i] = 1'b1;
            end
            if (pick_idx == SEL_W'(i)) pick_grant[i] = 1'b1;
        end
    end

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            src_id    <= '0;
            num_out   <= '0;
            valid_out <= 1'b0;
            dwell_cnt <= '0;
            last_ptr  <= SEL_W'(N_SRC - 1);
        end else if (pin_en) begin
            // The pin switch outranks dwell expiry and owner drop in every state.
            state     <= PINNED;
            grant     <= pin_grant;
            src_id    <= pin_sel;
            valid_out <= pin_ok;
            num_out   <= pin_ok ? pin_data : '0;
            dwell_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= SHOW;
                        grant     <= pick_grant;
                        src_id    <= pick_idx;
                        valid_out <= 1'b1;
                        dwell_cnt <= '0;
                        last_ptr  <= pick_idx;
                    end
                end
                SHOW: begin
                    if (dwell_done || !owner_req) begin
                        if (pick_found) begin
                            grant     <= pick_grant;
                            src_id    <= pick_idx;
                            num_out   <= owner_data;
                            dwell_cnt <= '0;
                            last_ptr  <= pick_idx;
                        end else begin
                            state     <= IDLE;
                            grant     <= '0;
                            valid_out <= 1'b0;
                        end
                    end else begin
                        // Only reached below DWELL_CYCLES-1, so the count saturates.
                        num_out   <= owner_data;
                        dwell_cnt <= dwell_cnt + CNT_W'(1);
                    end
                end
                PINNED: begin
                    state     <= IDLE;
                    grant     <= '0;
                    valid_out <= 1'b0;
                    last_ptr  <= pin_sel;
                end
                default: begin
                    state     <= IDLE;
                    grant     <= '0;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed bench for display_source_arbiter with N_SRC=4 and a 4-cycle dwell.
// Each task drives one scenario and compares outputs against hand-derived values.
module tb_display_source_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [51:0] data = {13'd4321, 13'd1234, 13'd1111, 13'd100};
    logic        pin_en = 1'b0;
    logic [1:0]  pin_sel = '0;
    logic [3:0]  grant;
    logic [1:0]  src_id;
    logic [12:0] num_out;
    logic        valid_out;

    int tests = 0;
    int fails = 0;

    logic [3:0] rot_exp [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

    display_source_arbiter #(
        .N_SRC        (4),
        .NUM_W        (13),
        .DWELL_CYCLES (4),
        .CNT_W        (27)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data      (data),
        .pin_en    (pin_en),
        .pin_sel   (pin_sel),
        .grant     (grant),
        .src_id    (src_id),
        .num_out   (num_out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        pin_en  = 1'b0;
        pin_sel = '0;
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick(1);
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        tests++; if (src_id !== 2'd0) begin fails++; $display("FAIL reset_src_id: got %0d expected 0", src_id); end
        tests++; if (num_out !== 13'd0) begin fails++; $display("FAIL reset_num: got %0d expected 0", num_out); end
        tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        rst_n = 1'b1;
        tick(3);
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL idle_grant: got %b expected 0000", grant); end
        tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b expected 0", valid_out); end
        tests++; if (num_out !== 13'd0) begin fails++; $display("FAIL idle_num: got %0d expected 0", num_out); end
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick(1);
        tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL single_grant: got %b expected 0100", grant); end
        tests++; if (src_id !== 2'd2) begin fails++; $display("FAIL single_src_id: got %0d expected 2", src_id); end
        tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", valid_out); end
        tick(1);
        tests++; if (num_out !== 13'd1234) begin fails++; $display("FAIL single_num: got %0d expected 1234", num_out); end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL single_hold cycle %0d: got %b expected 0100", i, grant); end
        end
        req = 4'b0000;
        tick(1);
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL drop_idle_grant: got %b expected 0000", grant); end
        tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL drop_idle_valid: got %b expected 0", valid_out); end
        tests++; if (num_out !== 13'd1234) begin fails++; $display("FAIL drop_idle_num: got %0d expected 1234", num_out); end
    endtask

    task automatic test_rotation();
        do_reset();
        req = 4'b1011;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            tests++; if (grant !== rot_exp[i/4]) begin fails++; $display("FAIL rotation cycle %0d: got %b expected %b", i, grant, rot_exp[i/4]); end
        end
        req = 4'b0000;
        tick(2);
    endtask

    task automatic test_early_drop();
        do_reset();
        req = 4'b1001;
        tick(2);
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL early_pre: got %b expected 0001", grant); end
        req = 4'b1000;
        tick(1);
        tests++; if (grant !== 4'b1000) begin fails++; $display("FAIL early_drop_grant: got %b expected 1000", grant); end
        req = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            tests++; if (grant !== 4'b1000) begin fails++; $display("FAIL early_dwell_reload cycle %0d: got %b expected 1000", i, grant); end
        end
        tick(1);
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL early_after_dwell: got %b expected 0001", grant); end
        req = 4'b0000;
        tick(2);
    endtask

    task automatic test_pin();
        do_reset();
        req = 4'b0010;
        tick(2);
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL pin_pre: got %b expected 0010", grant); end
        pin_en  = 1'b1;
        pin_sel = 2'd3;
        tick(1);
        tests++; if (grant !== 4'b1000) begin fails++; $display("FAIL pin3_grant: got %b expected 1000", grant); end
        tests++; if (src_id !== 2'd3) begin fails++; $display("FAIL pin3_src_id: got %0d expected 3", src_id); end
        tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL pin3_valid: got %b expected 1", valid_out); end
        tests++; if (num_out !== 13'd4321) begin fails++; $display("FAIL pin3_num: got %0d expected 4321", num_out); end
        pin_sel = 2'd0;
        tick(1);
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL pin0_grant: got %b expected 0001", grant); end
        tests++; if (num_out !== 13'd100) begin fails++; $display("FAIL pin0_num: got %0d expected 100", num_out); end
        pin_en = 1'b0;
        req    = 4'b0011;
        tick(1);
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL unpin_idle_grant: got %b expected 0000", grant); end
        tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL unpin_idle_valid: got %b expected 0", valid_out); end
        tick(1);
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL unpin_resume: got %b expected 0010", grant); end
        tests++; if (src_id !== 2'd1) begin fails++; $display("FAIL unpin_src_id: got %0d expected 1", src_id); end
        tick(3);
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL unpin_hold: got %b expected 0010", grant); end
        tick(1);
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL unpin_next: got %b expected 0001", grant); end
        req = 4'b0000;
        tick(2);
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 4'b0011;
        tick(4);
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL simul_pre: got %b expected 0001", grant); end
        pin_en  = 1'b1;
        pin_sel = 2'd2;
        tick(1);
        tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL simul_grant: got %b expected 0100", grant); end
        tests++; if (src_id !== 2'd2) begin fails++; $display("FAIL simul_src_id: got %0d expected 2", src_id); end
        tests++; if (num_out !== 13'd1234) begin fails++; $display("FAIL simul_num: got %0d expected 1234", num_out); end
        pin_en = 1'b0;
        req    = 4'b0000;
        tick(2);
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        tick(2);
        tests++; if (num_out !== 13'd1234) begin fails++; $display("FAIL areset_pre_num: got %0d expected 1234", num_out); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL areset_grant: got %b expected 0000", grant); end
        tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL areset_valid: got %b expected 0", valid_out); end
        tests++; if (num_out !== 13'd0) begin fails++; $display("FAIL areset_num: got %0d expected 0", num_out); end
        req = 4'b0000;
        #1;
        rst_n = 1'b1;
        tick(2);
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL areset_idle_grant: got %b expected 0000", grant); end
        tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL areset_idle_valid: got %b expected 0", valid_out); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_early_drop();
        test_pin();
        test_simultaneous();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
